// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA pipeline: colour depth, pixel word type,
// SVGA 800x600@60 timing defaults (shared with the timing generator) and the
// line-buffer writer FSM state encoding.
// -----------------------------------------------------------------------------
package vga_pkg;

    // Colour depth and pixel word: {R, G, B}, R in the MSBs.
    localparam int COLOR_BITS = 4;
    localparam int PIXEL_W    = 3 * COLOR_BITS;

    typedef logic [PIXEL_W-1:0] pixel_t;

    // SVGA 800x600@60 (40 MHz pixel clock) timing defaults.
    localparam int SVGA_H_VISIBLE = 800;
    localparam int SVGA_H_FRONT   = 40;
    localparam int SVGA_H_SYNC    = 128;
    localparam int SVGA_H_BACK    = 88;
    localparam int SVGA_V_VISIBLE = 600;
    localparam int SVGA_V_FRONT   = 1;
    localparam int SVGA_V_SYNC    = 4;
    localparam int SVGA_V_BACK    = 23;

    // Line-buffer writer FSM states.
    localparam logic [0:0] WR_FILL = 1'b0;  // accepting words into the fill bank
    localparam logic [0:0] WR_WAIT = 1'b1;  // line complete, held until a swap

endpackage : vga_pkg

// File: rtl/vga_dual_bank_ram.sv
// -----------------------------------------------------------------------------
// vga_dual_bank_ram
// Two banks of DEPTH pixel words, one write port and one synchronous read port.
// Addresses are {bank, index}. No reset, so it maps onto block RAM (M9K).
//
// Ports:
//   clk_i      pixel clock
//   we_i       write enable
//   wr_addr_i  write address {bank, index}
//   wr_data_i  write data
//   re_i       read enable
//   rd_addr_i  read address {bank, index}
//   rd_data_o  read data, valid the cycle after re_i
// -----------------------------------------------------------------------------
module vga_dual_bank_ram
    import vga_pkg::*;
#(
    parameter int DEPTH = SVGA_H_VISIBLE,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int WIDTH = PIXEL_W
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W:0]   wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             re_i,
    input  logic [IDX_W:0]   rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [2][DEPTH];

    // NOTE: storage arrays carry no reset; a reset would stop block-RAM
    // inference, and stale contents are masked by the stored line lengths.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_addr_i[IDX_W]][wr_addr_i[IDX_W-1:0]] <= wr_data_i;
        end
        if (re_i) begin
            rd_data_o <= mem_q[rd_addr_i[IDX_W]][rd_addr_i[IDX_W-1:0]];
        end
    end

endmodule : vga_dual_bank_ram

// File: rtl/vga_line_buffer.sv
// -----------------------------------------------------------------------------
// vga_line_buffer
// Ping-pong line buffer between the pixel source and the VGA timing stage.
// One bank is filled under valid/ready while the other is streamed out.
// A LINE_SWAP that arrives before the fill bank holds a complete line is an
// underrun: the displayed line repeats and filling carries on where it was.
//
// Ports:
//   VGA_CLK         pixel clock (rising edge)
//   RESET_N         asynchronous active-low reset
//   WR_VALID/READY  write handshake, WR_DATA = {R,G,B}, WR_LAST ends a line
//   RD_EN           visible area, advances the read pointer
//   LINE_SWAP       one-cycle strobe in horizontal blanking
//   VGA_R/G/B       pixel out, one cycle after RD_EN; black past the line end
//   UNDERRUN        sticky underrun flag
//   UNDERRUN_COUNT  saturating underrun count
// -----------------------------------------------------------------------------
module vga_line_buffer
    import vga_pkg::*;
#(
    parameter int H_VISIBLE_AREA = SVGA_H_VISIBLE
) (
    input  logic                  VGA_CLK,
    input  logic                  RESET_N,
    input  logic                  WR_VALID,
    output logic                  WR_READY,
    input  logic [PIXEL_W-1:0]    WR_DATA,
    input  logic                  WR_LAST,
    input  logic                  RD_EN,
    input  logic                  LINE_SWAP,
    output logic [COLOR_BITS-1:0] VGA_R,
    output logic [COLOR_BITS-1:0] VGA_G,
    output logic [COLOR_BITS-1:0] VGA_B,
    output logic                  UNDERRUN,
    output logic [15:0]           UNDERRUN_COUNT
);

    localparam int IDX_W = $clog2(H_VISIBLE_AREA);
    localparam int LEN_W = $clog2(H_VISIBLE_AREA + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(H_VISIBLE_AREA - 1);

    logic [0:0]       state_q,    state_d;
    logic             wr_sel_q,   wr_sel_d;
    logic [IDX_W-1:0] wr_addr_q,  wr_addr_d;
    logic [IDX_W-1:0] rd_addr_q,  rd_addr_d;
    logic [LEN_W-1:0] len_q [2];
    logic [LEN_W-1:0] len_d [2];
    logic             rd_hit_q,   rd_hit_d;
    logic             underrun_q, underrun_d;
    logic [15:0]      ucount_q,   ucount_d;

    logic             disp_sel;
    logic             wr_fire;
    logic             wr_done;
    logic             line_ready;
    pixel_t           ram_rd_data;

    assign disp_sel = ~wr_sel_q;
    assign WR_READY = (state_q == WR_FILL);
    assign wr_fire  = WR_VALID && WR_READY;
    assign wr_done  = wr_fire && (WR_LAST || (wr_addr_q == LAST_IDX));
    // A line finishing in the same cycle as the swap counts as complete.
    assign line_ready = (state_q == WR_WAIT) || wr_done;

    // NOTE: every next-state signal takes its current value first, so no path
    // through this block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        wr_sel_d   = wr_sel_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        len_d      = len_q;
        underrun_d = underrun_q;
        ucount_d   = ucount_q;

        if (wr_done) begin
            len_d[wr_sel_q] = LEN_W'(wr_addr_q) + 1'b1;
            state_d         = WR_WAIT;
        end else if (wr_fire) begin
            wr_addr_d = wr_addr_q + 1'b1;
        end

        if (LINE_SWAP) begin
            // The swap wins over RD_EN; the read side always restarts.
            rd_addr_d = '0;
            if (line_ready) begin
                wr_sel_d  = ~wr_sel_q;
                wr_addr_d = '0;
                state_d   = WR_FILL;
            end else begin
                // Keep the banks and the partial line; only log the miss.
                underrun_d = 1'b1;
                if (ucount_q != 16'hFFFF) begin
                    ucount_d = ucount_q + 16'd1;
                end
            end
        end else if (RD_EN && (rd_addr_q != LAST_IDX)) begin
            rd_addr_d = rd_addr_q + 1'b1;
        end

        // Pixels past the stored length of the displayed line read as black.
        rd_hit_d = RD_EN && (LEN_W'(rd_addr_q) < len_q[disp_sel]);
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= WR_FILL;
            wr_sel_q   <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            len_q      <= '{default: '0};
            rd_hit_q   <= 1'b0;
            underrun_q <= 1'b0;
            ucount_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_sel_q   <= wr_sel_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            len_q      <= len_d;
            rd_hit_q   <= rd_hit_d;
            underrun_q <= underrun_d;
            ucount_q   <= ucount_d;
        end
    end

    vga_dual_bank_ram #(
        .DEPTH (H_VISIBLE_AREA),
        .IDX_W (IDX_W),
        .WIDTH (PIXEL_W)
    ) u_ram (
        .clk_i     (VGA_CLK),
        .we_i      (wr_fire),
        .wr_addr_i ({wr_sel_q, wr_addr_q}),
        .wr_data_i (WR_DATA),
        .re_i      (RD_EN),
        .rd_addr_i ({disp_sel, rd_addr_q}),
        .rd_data_o (ram_rd_data)
    );

    // The RAM output register is the pixel register; the reset-cleared hit
    // flag blanks it, so reset and out-of-line reads give black at once.
    assign {VGA_R, VGA_G, VGA_B} = rd_hit_q ? ram_rd_data : '0;
    assign UNDERRUN              = underrun_q;
    assign UNDERRUN_COUNT        = ucount_q;

endmodule : vga_line_buffer

// File: tb/tb_vga_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_vga_line_buffer
// Self-checking bench for vga_line_buffer with an 8-pixel line. A line-level
// reference model (queues for the line being filled and the line on display)
// predicts every output each cycle; a directed vector table and hand-written
// sequences cover the corner cases; random traffic finishes the run.
// -----------------------------------------------------------------------------
module tb_vga_line_buffer;

    localparam int H      = 8;
    localparam int PW     = 12;
    localparam int N_RAND = 3000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [PW-1:0] wr_data;
    logic          wr_last;
    logic          rd_en;
    logic          line_swap;
    logic [3:0]    vga_r, vga_g, vga_b;
    logic          underrun;
    logic [15:0]   underrun_count;
    logic [PW-1:0] rgb;

    always #5 clk = ~clk;

    assign rgb = {vga_r, vga_g, vga_b};

    vga_line_buffer #(.H_VISIBLE_AREA(H)) dut (
        .VGA_CLK        (clk),
        .RESET_N        (rst_n),
        .WR_VALID       (wr_valid),
        .WR_READY       (wr_ready),
        .WR_DATA        (wr_data),
        .WR_LAST        (wr_last),
        .RD_EN          (rd_en),
        .LINE_SWAP      (line_swap),
        .VGA_R          (vga_r),
        .VGA_G          (vga_g),
        .VGA_B          (vga_b),
        .UNDERRUN       (underrun),
        .UNDERRUN_COUNT (underrun_count)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a line is a queue of pixels.
    logic [PW-1:0] m_fill[$];   // line being built by the producer
    logic [PW-1:0] m_disp[$];   // line currently on display
    bit            m_done;      // m_fill holds a finished line
    int            m_rd;        // read position in m_disp
    int            m_cnt;
    bit            m_flag;
    logic [PW-1:0] m_pix;

    typedef struct {
        logic          v;
        logic [PW-1:0] d;
        logic          l;
        logic          re;
        logic          sw;
        logic          exp_ready;
        logic [PW-1:0] exp_rgb;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [PW-1:0] d, input logic l,
                                input logic re, input logic sw,
                                input logic er, input logic [PW-1:0] eg);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.re = re; t.sw = sw;
        t.exp_ready = er; t.exp_rgb = eg;
        return t;
    endfunction

    task automatic model_reset();
        m_fill.delete();
        m_disp.delete();
        m_done = 1'b0;
        m_rd   = 0;
        m_cnt  = 0;
        m_flag = 1'b0;
        m_pix  = '0;
    endtask

    // Apply one cycle of inputs (entered at posedge+1), advance the model,
    // then compare all outputs at posedge+1 of the next edge.
    task automatic cycle(input logic v, input logic [PW-1:0] d, input logic l,
                         input logic re, input logic sw);
        wr_valid  = v;
        wr_data   = d;
        wr_last   = l;
        rd_en     = re;
        line_swap = sw;

        m_pix = (re && (m_rd < m_disp.size())) ? m_disp[m_rd] : '0;
        if (v && !m_done) begin
            m_fill.push_back(d);
            if (l || (m_fill.size() == H)) m_done = 1'b1;
        end
        if (sw) begin
            if (m_done) begin
                m_disp = m_fill;
                m_fill.delete();
                m_done = 1'b0;
            end else begin
                m_flag = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt++;
            end
            m_rd = 0;
        end else if (re && (m_rd < H - 1)) begin
            m_rd++;
        end

        @(posedge clk);
        #1;
        check("pixel", 32'(rgb), 32'(m_pix));
        check("wr_ready", 32'(wr_ready), 32'(!m_done));
        check("underrun", 32'(underrun), 32'(m_flag));
        check("underrun_count", 32'(underrun_count), 32'(m_cnt));
    endtask

    task automatic idle_inputs();
        wr_valid  = 1'b0;
        wr_data   = '0;
        wr_last   = 1'b0;
        rd_en     = 1'b0;
        line_swap = 1'b0;
    endtask

    // Entered at posedge+1; asserts reset between edges and checks that the
    // outputs clear without waiting for a clock.
    task automatic async_reset();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pixel", 32'(rgb), 32'h0);
        check("rst_ready", 32'(wr_ready), 32'h1);
        check("rst_underrun", 32'(underrun), 32'h0);
        check("rst_count", 32'(underrun_count), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic read_line();
        for (int i = 0; i < H; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check("init_pixel", 32'(rgb), 32'h0);
        check("init_ready", 32'(wr_ready), 32'h1);
        check("init_underrun", 32'(underrun), 32'h0);
        check("init_count", 32'(underrun_count), 32'h0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- Directed vector table ----
        for (int i = 0; i < H; i++) tbl.push_back(mk(0, '0, 0, 1, 0, 1, '0));
        for (int i = 0; i < H; i++)
            tbl.push_back(mk(1, PW'(i + 1), 0, 0, 0, (i != H - 1), '0));
        tbl.push_back(mk(0, '0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(0, '0, 0, 0, 1, 1, '0));
        for (int i = 0; i < H; i++) tbl.push_back(mk(0, '0, 0, 1, 0, 1, PW'(i + 1)));
        tbl.push_back(mk(0, '0, 0, 0, 0, 1, '0));
        tbl.push_back(mk(1, 12'h0A0, 0, 0, 0, 1, '0));
        tbl.push_back(mk(1, 12'h0B0, 0, 0, 0, 1, '0));
        tbl.push_back(mk(1, 12'hF00, 1, 0, 0, 0, '0));
        tbl.push_back(mk(0, '0, 0, 0, 1, 1, '0));
        tbl.push_back(mk(0, '0, 0, 1, 0, 1, 12'h0A0));
        tbl.push_back(mk(0, '0, 0, 1, 0, 1, 12'h0B0));
        tbl.push_back(mk(0, '0, 0, 1, 0, 1, 12'hF00));
        for (int i = 3; i < H; i++) tbl.push_back(mk(0, '0, 0, 1, 0, 1, '0));
        tbl.push_back(mk(0, '0, 0, 0, 0, 1, '0));

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].re, tbl[i].sw);
            check("tbl_rgb", 32'(rgb), 32'(tbl[i].exp_rgb));
            check("tbl_ready", 32'(wr_ready), 32'(tbl[i].exp_ready));
        end

        // ---- Underrun with 4 of 8 pixels written ----
        for (int i = 0; i < H; i++) cycle(1'b1, PW'(12'h101 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, PW'(12'h201 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("ur_flag", 32'(underrun), 32'h1);
        check("ur_count", 32'(underrun_count), 32'h1);
        check("ur_ready", 32'(wr_ready), 32'h1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("ur_repeat", 32'(rgb), 32'h101);
        for (int i = 1; i < H; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 4; i < H; i++) cycle(1'b1, PW'(12'h201 + i), 1'b0, 1'b0, 1'b0);
        check("ur_resume_full", 32'(wr_ready), 32'h0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        read_line();

        // ---- Last write and swap in the same cycle ----
        for (int i = 0; i < H - 1; i++) cycle(1'b1, PW'(12'h301 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 12'h308, 1'b0, 1'b0, 1'b1);
        check("sc_count", 32'(underrun_count), 32'h1);
        check("sc_ready", 32'(wr_ready), 32'h1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("sc_first", 32'(rgb), 32'h301);
        for (int i = 1; i < H; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // ---- Reset mid-fill and mid-read ----
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, PW'(12'h501 + i), 1'b0, 1'b1, 1'b0);
        check("pre_rst_pixel", 32'(rgb), 32'h303);
        async_reset();
        read_line();

        // ---- Counter saturation ----
        idle_inputs();
        line_swap = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        m_cnt  = 16'hFFFF;
        m_flag = 1'b1;
        m_rd   = 0;
        check("sat_reach", 32'(underrun_count), 32'hFFFF);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("sat_hold", 32'(underrun_count), 32'hFFFF);

        // ---- Random traffic against the model ----
        async_reset();
        for (int i = 0; i < N_RAND; i++) begin
            cycle(($urandom_range(0, 3) != 0), PW'($urandom), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 11) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vga_line_buffer

// File: doc/vga_line_buffer.md
# vga_line_buffer

Ping-pong line buffer between the pixel source (pattern/frame generator) and the VGA sync/timing stage, in the `VGA_CLK` domain. An upstream producer writes one visible line of 12-bit RGB444 pixels under a valid/ready handshake while the previously completed line is streamed out. The timing stage drives the read enable and the line-swap strobe. Missing lines are reported as underruns, and the stale line is repeated.

## Interface
- `H_VISIBLE_AREA`, 800, pixels per visible line; bank depth.
- `COLOR_BITS`, 4, bits per colour channel; pixel word is 3*COLOR_BITS.
- `VGA_CLK` input 1: pixel clock; all logic is on its rising edge.
- `RESET_N` input 1: asynchronous, active-low reset.
- `WR_VALID` input 1: producer offers `WR_DATA`.
- `WR_READY` output 1: buffer accepts a word; transfer occurs when both `WR_VALID` and `WR_READY` are high.
- `WR_DATA` input 3*COLOR_BITS: pixel as {R,G,B}, R in the MSBs.
- `WR_LAST` input 1: qualifies the accepted word as the final pixel of the line.
- `RD_EN` input 1: timing stage is in the visible area; advances the read pointer.
- `LINE_SWAP` input 1: one-cycle strobe in horizontal blanking, at end of the visible line.
- `VGA_R`, `VGA_G`, `VGA_B` output COLOR_BITS each: registered pixel out.
- `UNDERRUN` output 1: sticky flag.
- `UNDERRUN_COUNT` output 16: saturating count of underruns.

## Operation
- Storage is two banks of H_VISIBLE_AREA words, with a per-bank stored length `len[b]` of clog2(H_VISIBLE_AREA+1) bits.
- Control registers:
  - `wr_sel`: bank being filled.
  - `disp_sel`: equals ~`wr_sel` at all times.
  - `wr_addr`, `rd_addr`.
- Writer FSM states:
  - FILL: `WR_READY`=1. Each accepted word is written at `wr_addr`, and `wr_addr` increments. On an accepted word with `WR_LAST`=1 or `wr_addr`==H_VISIBLE_AREA-1: set `len[wr_sel]`=`wr_addr`+1 and go to WAIT.
  - WAIT: `WR_READY`=0. The line is complete and held until a swap.
- `LINE_SWAP` in WAIT:
  - `disp_sel`<=`wr_sel`, `wr_sel`<=~`wr_sel`.
  - `wr_addr`<=0; FSM goes to FILL.
- `LINE_SWAP` in FILL is an underrun:
  - No bank change; the displayed line repeats.
  - The partial line is kept and filling continues.
  - `UNDERRUN`<=1; `UNDERRUN_COUNT` increments, saturating at 16'hFFFF.
- The transition to WAIT and `LINE_SWAP` may occur in the same cycle. This is treated as WAIT: the word is written, the swap occurs, and the FSM enters FILL on the new bank. No underrun is counted.
- Read side:
  - `rd_addr` resets to 0 on every `LINE_SWAP`, including underruns.
  - While `RD_EN`=1, `rd_addr` increments and saturates at H_VISIBLE_AREA-1.
- Output pixel: if the previous cycle had `RD_EN`=1 and `rd_addr`<`len[disp_sel]`, output the stored word. Otherwise output 0 (black). Pixels beyond a short line are therefore black.
- `LINE_SWAP` together with `RD_EN` is a protocol violation. The swap still takes priority, and `rd_addr` is forced to 0.

## Timing
- Read latency is 1 cycle: the pixel for the `RD_EN` cycle at `rd_addr` n appears on `VGA_R/G/B` in the following cycle. The timing stage delays HS/VS by one cycle to match.
- Write acceptance takes 1 word per cycle, with no bubbles inside a line.
- `WR_READY` drops in the cycle after the last word is accepted. It reasserts in the cycle after `LINE_SWAP`.
- Reset values:
  - `WR_READY`=1 (FILL), `wr_sel`=0, `disp_sel`=1.
  - `len[0]`=`len[1]`=0, so output is black until the first swap.
  - `rd_addr`=`wr_addr`=0.
  - `VGA_R/G/B`=0, `UNDERRUN`=0, `UNDERRUN_COUNT`=0.
- Reset mid-line aborts both sides immediately. The partial line is discarded by clearing `len`; memory contents are don't-care.

## Structure
- Shared package `vga_pkg`: COLOR_BITS, the pixel word type/width, and the SVGA 800x600@60 timing defaults shared with the timing generator.
- Sub-module `vga_dual_bank_ram`:
  - 2*H_VISIBLE_AREA words, one write port and one synchronous read port, no reset.
  - Address = {bank, index}.
  - Infers M9K on DE10-Lite.
- The top level holds the FSM, pointers, lengths, output register and underrun counter.

## Test plan
All scenarios use H_VISIBLE_AREA=8.
- Reset, then `RD_EN` for 8 cycles with no swap -> outputs all 0, `WR_READY`=1, `UNDERRUN`=0.
- Write pixels 12'h001..12'h008, then `LINE_SWAP`, then `RD_EN` for 8 cycles -> RGB sequence 001..008, each 1 cycle after the corresponding `RD_EN` cycle. `WR_READY` is low for the cycles between the 8th write and the swap.
- Write 3 pixels with `WR_LAST` on 12'hF00, swap, read 8 -> 3 pixels then 5 black.
- `LINE_SWAP` while 4 of 8 pixels are written -> `UNDERRUN`=1, count=1, the previous line repeats, and writing continues at `wr_addr`=4.
- 8th write and `LINE_SWAP` in the same cycle -> swap happens, count unchanged, `WR_READY`=1 on the next cycle on the other bank.
- Assert `RESET_N` low mid-fill and mid-read -> immediate black output, `WR_READY`=1, count=0. Force the count to 16'hFFFF, then underrun -> it stays at FFFF.
